icache_miss_handler: RTL and testbench

//  Miss engine between icache lookup and mem_controller icache port. Takes one block miss
//  and issues BUS_LOAD, retrying until accepted. Captures the returned tag, waits for data

---
 rtl/icache_miss_handler_pkg.sv | 26 ++
 rtl/icache_miss_handler.sv | 190 +++++++++++++++++++
 tb/tb_icache_miss_handler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_miss_handler_pkg.sv
// Shared types for the icache miss engine: bus command, response owner and FSM state.
package icache_miss_handler_pkg;

  localparam int XLEN           = 32;
  localparam int ICMH_BLK_BYTES = 8;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_e;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } dest_cache_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    PF_REQ    = 3'd3,
    PF_WAIT   = 3'd4
  } icmh_state_e;

endpackage

// File: rtl/icache_miss_handler.sv
// Single-demand icache miss engine: issues BUS_LOAD until accepted, waits for the tagged
// block and writes it into the icache. Define ICACHE_PREFETCH_EN for next-block prefetch.
module icache_miss_handler
  import icache_miss_handler_pkg::*;
#(
  parameter int BLK_OFF_BITS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              miss_valid,
  input  logic [XLEN-1:0]   miss_addr,
  output logic              miss_ready,
  input  logic              squash,
  output bus_command_e      icache_command,
  output logic [XLEN-1:0]   icache_addr,
  input  logic [3:0]        control2cache_response,
  input  dest_cache_e       control2cache_response_which,
  input  logic [63:0]       control2cache_data,
  input  logic [3:0]        control2cache_tag,
  input  dest_cache_e       control2cache_tag_which,
  output logic              fill_valid,
  output logic [XLEN-1:0]   fill_addr,
  output logic [63:0]       fill_data,
  output logic              fill_is_prefetch,
  output icmh_state_e       fsm_state
);

  // Handshake: a miss transfers on a rising clock edge where miss_valid && miss_ready.
  localparam logic [XLEN-1:0] BLK_STEP = XLEN'(1) << BLK_OFF_BITS;
  localparam logic [XLEN-1:0] BLK_MASK = ~(BLK_STEP - XLEN'(1));

  icmh_state_e     state;
  logic [XLEN-1:0] req_addr;
  logic [3:0]      saved_tag;
  logic            miss_fire;
  logic [XLEN-1:0] miss_blk;
  logic            resp_ok;
  logic            data_ok;

  assign miss_fire = miss_valid && miss_ready;
  assign miss_blk  = miss_addr & BLK_MASK;
  assign resp_ok   = (control2cache_response != 4'd0) && (control2cache_response_which == ICACHE);
  assign data_ok   = (control2cache_tag != 4'd0) && (control2cache_tag == saved_tag) &&
                     (control2cache_tag_which == ICACHE);
  assign fsm_state = state;

`ifdef ICACHE_PREFETCH_EN
  logic            pend_valid;
  logic [XLEN-1:0] pend_addr;
  logic            promoted;
  logic            fill_pf_q;
  logic            same_blk;

  assign same_blk         = (miss_blk == req_addr);
  assign fill_is_prefetch = fill_pf_q;
`else
  assign fill_is_prefetch = 1'b0;
`endif

  always_comb begin
    miss_ready = 1'b0;
    case (state)
      IDLE:    miss_ready = 1'b1;
`ifdef ICACHE_PREFETCH_EN
      PF_REQ,
      PF_WAIT: miss_ready = !pend_valid && !promoted;
`endif
      default: miss_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      req_addr       <= '0;
      saved_tag      <= 4'd0;
      icache_command <= BUS_NONE;
      icache_addr    <= '0;
      fill_valid     <= 1'b0;
      fill_addr      <= '0;
      fill_data      <= 64'd0;
`ifdef ICACHE_PREFETCH_EN
      pend_valid     <= 1'b0;
      pend_addr      <= '0;
      promoted       <= 1'b0;
      fill_pf_q      <= 1'b0;
`endif
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_fire) begin
            req_addr       <= miss_blk;
            icache_addr    <= miss_blk;
            icache_command <= BUS_LOAD;
            state          <= REQ;
          end
        end
        REQ: begin
          // An acceptance in the same cycle as squash still wins.
          if (resp_ok) begin
            saved_tag      <= control2cache_response;
            icache_command <= BUS_NONE;
            state          <= WAIT_DATA;
          end else if (squash) begin
            icache_command <= BUS_NONE;
            state          <= IDLE;
          end
        end
        WAIT_DATA: begin
          if (data_ok) begin
            fill_valid <= 1'b1;
            fill_addr  <= req_addr;
            fill_data  <= control2cache_data;
`ifdef ICACHE_PREFETCH_EN
            fill_pf_q      <= 1'b0;
            req_addr       <= req_addr + BLK_STEP;
            icache_addr    <= req_addr + BLK_STEP;
            icache_command <= BUS_LOAD;
            state          <= PF_REQ;
`else
            state      <= IDLE;
`endif
          end
        end
`ifdef ICACHE_PREFETCH_EN
        PF_REQ: begin
          if (resp_ok) begin
            saved_tag      <= control2cache_response;
            icache_command <= BUS_NONE;
            state          <= PF_WAIT;
            if (miss_fire && same_blk) begin
              promoted <= 1'b1;
            end else if (miss_fire) begin
              pend_valid <= 1'b1;
              pend_addr  <= miss_blk;
            end
          end else if (miss_fire && !same_blk) begin
            // The un-accepted prefetch is abandoned in favour of the new demand.
            req_addr    <= miss_blk;
            icache_addr <= miss_blk;
            promoted    <= 1'b0;
            state       <= REQ;
          end else if (squash) begin
            icache_command <= BUS_NONE;
            promoted       <= 1'b0;
            state          <= IDLE;
          end else if (miss_fire) begin
            promoted <= 1'b1;
          end
        end
        PF_WAIT: begin
          if (miss_fire && same_blk) begin
            promoted <= 1'b1;
          end else if (miss_fire) begin
            pend_valid <= 1'b1;
            pend_addr  <= miss_blk;
          end
          if (data_ok) begin
            fill_valid <= 1'b1;
            fill_addr  <= req_addr;
            fill_data  <= control2cache_data;
            fill_pf_q  <= !(promoted || (miss_fire && same_blk));
            promoted   <= 1'b0;
            pend_valid <= 1'b0;
            if (pend_valid) begin
              req_addr       <= pend_addr;
              icache_addr    <= pend_addr;
              icache_command <= BUS_LOAD;
              state          <= REQ;
            end else if (miss_fire && !same_blk) begin
              req_addr       <= miss_blk;
              icache_addr    <= miss_blk;
              icache_command <= BUS_LOAD;
              state          <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif
        default: begin
          icache_command <= BUS_NONE;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_miss_handler.sv
// Scoreboard bench for icache_miss_handler: directed misses, expected bus requests and
// fills queued by the stimulus, popped and compared by a negedge monitor.
module tb_icache_miss_handler;
  import icache_miss_handler_pkg::*;

  logic            clock;
  logic            reset;
  logic            miss_valid;
  logic [XLEN-1:0] miss_addr;
  logic            miss_ready;
  logic            squash;
  bus_command_e    icache_command;
  logic [XLEN-1:0] icache_addr;
  logic [3:0]      control2cache_response;
  dest_cache_e     control2cache_response_which;
  logic [63:0]     control2cache_data;
  logic [3:0]      control2cache_tag;
  dest_cache_e     control2cache_tag_which;
  logic            fill_valid;
  logic [XLEN-1:0] fill_addr;
  logic [63:0]     fill_data;
  logic            fill_is_prefetch;
  icmh_state_e     fsm_state;

  int checks = 0;
  int errors = 0;
  int load_cycles = 0;
  logic [96:0]     fill_q[$];
  logic [XLEN-1:0] req_q[$];
  logic            prev_load = 1'b0;
  logic [XLEN-1:0] prev_addr = '0;

  icache_miss_handler dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .squash(squash),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .control2cache_response(control2cache_response),
    .control2cache_response_which(control2cache_response_which),
    .control2cache_data(control2cache_data),
    .control2cache_tag(control2cache_tag),
    .control2cache_tag_which(control2cache_tag_which),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_is_prefetch(fill_is_prefetch),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    logic [96:0]     ef;
    logic [XLEN-1:0] ea;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (fill_valid) begin
          if (fill_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fill: got %0h required none",
                     {fill_is_prefetch, fill_addr, fill_data});
          end else begin
            ef = fill_q.pop_front();
            check("fill", {31'd0, fill_is_prefetch, fill_addr, fill_data}, {31'd0, ef});
          end
        end
        if (icache_command == BUS_LOAD) begin
          load_cycles++;
          if (!(prev_load && prev_addr == icache_addr)) begin
            if (req_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_request: got %0h required none", icache_addr);
            end else begin
              ea = req_q.pop_front();
              check("request_addr", icache_addr, ea);
            end
          end
        end
        prev_load = (icache_command == BUS_LOAD);
        prev_addr = icache_addr;
      end else begin
        prev_load = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_miss(input logic [XLEN-1:0] a);
    int n;
    n = 0;
    miss_valid = 1'b1;
    miss_addr  = a;
    while (!miss_ready && n < 20) begin
      tick();
      n++;
    end
    check("miss_ready_before_accept", miss_ready, 1'b1);
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] t, input dest_cache_e w);
    control2cache_response       = t;
    control2cache_response_which = w;
    tick();
    control2cache_response       = 4'd0;
    control2cache_response_which = ICACHE;
  endtask

  task automatic send_data(input logic [3:0] t, input dest_cache_e w, input logic [63:0] d);
    control2cache_tag       = t;
    control2cache_tag_which = w;
    control2cache_data      = d;
    tick();
    control2cache_tag       = 4'd0;
    control2cache_tag_which = ICACHE;
  endtask

  task automatic wait_state(input icmh_state_e s, input string name);
    int n;
    n = 0;
    while (fsm_state != s && n < 20) begin
      tick();
      n++;
    end
    check(name, fsm_state, s);
  endtask

  // Demand fill; a prefetch build also expects the follow-on request, then squashes it.
  task automatic fill_demand(input logic [3:0] t, input logic [XLEN-1:0] a, input logic [63:0] d);
    fill_q.push_back({1'b0, a, d});
`ifdef ICACHE_PREFETCH_EN
    req_q.push_back(a + 32'h8);
`endif
    send_data(t, ICACHE, d);
`ifdef ICACHE_PREFETCH_EN
    squash = 1'b1;
    tick();
    squash = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b0;
    miss_valid = 1'b0;
    miss_addr = '0;
    squash = 1'b0;
    control2cache_response = 4'd0;
    control2cache_response_which = ICACHE;
    control2cache_data = 64'd0;
    control2cache_tag = 4'd0;
    control2cache_tag_which = ICACHE;
    repeat (2) tick();
    check("reset_cmd", icache_command, BUS_NONE);
    check("reset_addr", icache_addr, 32'h0);
    check("reset_fill_valid", fill_valid, 1'b0);
    check("reset_state", fsm_state, IDLE);
    reset = 1'b1;
    tick();
    check("idle_miss_ready", miss_ready, 1'b1);

    // 1: basic miss, aligned request, fill the cycle after the matching tag
    req_q.push_back(32'h0000_1230);
    issue_miss(32'h0000_1234);
    check("t1_cmd_load", icache_command, BUS_LOAD);
    check("t1_busy_miss_ready", miss_ready, 1'b0);
    respond(4'd3, ICACHE);
    check("t1_cmd_none", icache_command, BUS_NONE);
    check("t1_wait", fsm_state, WAIT_DATA);
    fill_demand(4'd3, 32'h0000_1230, 64'h0000_0000_DEAD_BEEF);
    tick();
    check("t1_fill_pulse", fill_valid, 1'b0);
    wait_state(IDLE, "t1_idle");

    // 2: retry while response is zero, one request held six cycles
    req_q.push_back(32'h0000_2000);
    load_cycles = 0;
    issue_miss(32'h0000_2005);
    repeat (5) respond(4'd0, ICACHE);
    check("t2_still_req", fsm_state, REQ);
    respond(4'd2, ICACHE);
    check("t2_load_cycles", load_cycles, 6);
    fill_demand(4'd2, 32'h0000_2000, 64'h0123_4567_89AB_CDEF);
    wait_state(IDLE, "t2_idle");

    // 3: DCACHE response ignored; wrong owner, wrong tag and tag 0 never fill
    req_q.push_back(32'h0000_3008);
    issue_miss(32'h0000_300F);
    respond(4'd4, DCACHE);
    check("t3_dcache_resp_ignored", fsm_state, REQ);
    respond(4'd4, ICACHE);
    send_data(4'd4, DCACHE, 64'h1111);
    send_data(4'd5, ICACHE, 64'h2222);
    send_data(4'd0, ICACHE, 64'h2223);
    check("t3_still_wait", fsm_state, WAIT_DATA);
    fill_demand(4'd4, 32'h0000_3008, 64'h3333_4444_5555_6666);
    wait_state(IDLE, "t3_idle");

    // 4: squash in REQ, accept beats squash, squash ignored while waiting
    req_q.push_back(32'h0000_4000);
    issue_miss(32'h0000_4000);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    check("t4_squash_idle", fsm_state, IDLE);
    check("t4_squash_cmd", icache_command, BUS_NONE);
    req_q.push_back(32'h0000_4020);
    issue_miss(32'h0000_4027);
    squash = 1'b1;
    respond(4'd7, ICACHE);
    squash = 1'b0;
    check("t4_accept_wins", fsm_state, WAIT_DATA);
    fill_demand(4'd7, 32'h0000_4020, 64'h7777);
    wait_state(IDLE, "t4_idle_a");
    req_q.push_back(32'h0000_4010);
    issue_miss(32'h0000_4010);
    respond(4'd6, ICACHE);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    check("t4_wait_ignores_squash", fsm_state, WAIT_DATA);
    fill_demand(4'd6, 32'h0000_4010, 64'h6666_0000_6666);
    wait_state(IDLE, "t4_idle_b");

    // 5: asynchronous reset mid-wait clears outputs immediately; late data is ignored
    req_q.push_back(32'h0000_5000);
    issue_miss(32'h0000_5000);
    respond(4'd9, ICACHE);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_state", fsm_state, IDLE);
    check("t5_async_cmd", icache_command, BUS_NONE);
    check("t5_async_addr", icache_addr, 32'h0);
    check("t5_async_fill_addr", fill_addr, 32'h0);
    check("t5_async_fill_data", fill_data, 64'h0);
    check("t5_async_fill_pf", fill_is_prefetch, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    send_data(4'd9, ICACHE, 64'h9999);
    tick();
    check("t5_no_fill_state", fsm_state, IDLE);

`ifdef ICACHE_PREFETCH_EN
    // 6: prefetch of next block, promotion, and a miss aborting an un-accepted prefetch
    req_q.push_back(32'h0000_0100);
    issue_miss(32'h0000_0100);
    respond(4'd1, ICACHE);
    fill_q.push_back({1'b0, 32'h0000_0100, 64'hA1});
    req_q.push_back(32'h0000_0108);
    send_data(4'd1, ICACHE, 64'hA1);
    check("t6_pf_req", fsm_state, PF_REQ);
    respond(4'd2, ICACHE);
    check("t6_pf_wait_ready", miss_ready, 1'b1);
    issue_miss(32'h0000_010C);
    check("t6_promoted_ready", miss_ready, 1'b0);
    fill_q.push_back({1'b0, 32'h0000_0108, 64'hA2});
    send_data(4'd2, ICACHE, 64'hA2);
    wait_state(IDLE, "t6_idle_a");
    req_q.push_back(32'h0000_0200);
    issue_miss(32'h0000_0200);
    respond(4'd3, ICACHE);
    fill_q.push_back({1'b0, 32'h0000_0200, 64'hB3});
    req_q.push_back(32'h0000_0208);
    send_data(4'd3, ICACHE, 64'hB3);
    req_q.push_back(32'h0000_0300);
    issue_miss(32'h0000_0300);
    check("t6_abort_req", fsm_state, REQ);
    respond(4'd4, ICACHE);
    fill_q.push_back({1'b0, 32'h0000_0300, 64'hC4});
    req_q.push_back(32'h0000_0308);
    send_data(4'd4, ICACHE, 64'hC4);
    respond(4'd5, ICACHE);
    fill_q.push_back({1'b1, 32'h0000_0308, 64'hD5});
    send_data(4'd5, ICACHE, 64'hD5);
    wait_state(IDLE, "t6_idle_b");
`endif

    // Final report
    repeat (3) tick();
    check("fill_q_drained", fill_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
